mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 10 +
 rtl/requests_pkg.sv | 17 +
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared arbiter definitions: the transaction state machine encoding.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } ArbState;

endpackage

// File: rtl/requests_pkg.sv
// Request/result types shared by the CPU-side MMUs and the memory system.
package requests_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        isWrite;
        logic        isPrivaliged;
        logic        isValid;
    } cpuMemRequest_t;

    typedef struct packed {
        logic [31:0] data;
        logic        isValid;
    } cpuMemResult_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single memory port.
// One transaction is outstanding at a time; a hung memory is aborted
// after TIMEOUT_CYCLES busy cycles and answered with data 0.
module mem_arbiter
    import requests_pkg::*;
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic           clock,
    input  logic           reset,
    input  cpuMemRequest_t port0_request,
    output cpuMemResult_t  port0_result,
    input  cpuMemRequest_t port1_request,
    output cpuMemResult_t  port1_result,
    output cpuMemRequest_t mem_request,
    input  cpuMemResult_t  mem_result,
    output logic           grant,
    output logic           busy,
    output logic           timeout_error
);

    localparam int            CW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    ArbState        state_r,         state_s;
    cpuMemRequest_t mem_request_r,   mem_request_s;
    cpuMemResult_t  port0_result_r,  port0_result_s;
    cpuMemResult_t  port1_result_r,  port1_result_s;
    logic           grant_r,         grant_s;
    logic           last_grant_r,    last_grant_s;
    logic           busy_r,          busy_s;
    logic           timeout_error_r, timeout_error_s;
    logic [CW-1:0]  count_r,         count_s;
    logic           winner_s;

    // State and all outputs are registered; reset abandons any transaction.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r         <= IDLE;
            mem_request_r   <= '0;
            port0_result_r  <= '0;
            port1_result_r  <= '0;
            grant_r         <= 1'b0;
            last_grant_r    <= 1'b1;
            busy_r          <= 1'b0;
            timeout_error_r <= 1'b0;
            count_r         <= '0;
        end else begin
            state_r         <= state_s;
            mem_request_r   <= mem_request_s;
            port0_result_r  <= port0_result_s;
            port1_result_r  <= port1_result_s;
            grant_r         <= grant_s;
            last_grant_r    <= last_grant_s;
            busy_r          <= busy_s;
            timeout_error_r <= timeout_error_s;
            count_r         <= count_s;
        end
    end

    // Round-robin pick, next-state and next-output logic.
    always_comb begin
        state_s         = state_r;
        mem_request_s   = mem_request_r;
        port0_result_s  = '0;
        port1_result_s  = '0;
        grant_s         = grant_r;
        last_grant_s    = last_grant_r;
        timeout_error_s = 1'b0;
        count_s         = count_r;

        // On contention the port that did not win last time goes first.
        if (port0_request.isValid && port1_request.isValid) begin
            winner_s = ~last_grant_r;
        end else if (port1_request.isValid) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end

        case (state_r)
            IDLE: begin
                if (port0_request.isValid || port1_request.isValid) begin
                    mem_request_s         = winner_s ? port1_request : port0_request;
                    mem_request_s.isValid = 1'b1;
                    grant_s               = winner_s;
                    count_s               = '0;
                    state_s               = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                // A real answer beats a timeout expiring on the same edge.
                if (mem_result.isValid || (count_r == CNT_LAST)) begin
                    mem_request_s.isValid = 1'b0;
                    last_grant_s          = grant_r;
                    timeout_error_s       = ~mem_result.isValid;
                    state_s               = RESPOND;
                    if (grant_r) begin
                        port1_result_s.data    = mem_result.isValid ? mem_result.data : 32'h0;
                        port1_result_s.isValid = 1'b1;
                    end else begin
                        port0_result_s.data    = mem_result.isValid ? mem_result.data : 32'h0;
                        port0_result_s.isValid = 1'b1;
                    end
                end else if (count_r != CNT_MAX) begin
                    count_s = count_r + CNT_ONE;
                end else begin
                    count_s = count_r;
                end
            end
            RESPOND: begin
                state_s = IDLE;
            end
            default: begin
                state_s               = IDLE;
                mem_request_s.isValid = 1'b0;
            end
        endcase

        busy_s = (state_s != IDLE);
    end

    assign mem_request   = mem_request_r;
    assign port0_result  = port0_result_r;
    assign port1_result  = port1_result_r;
    assign grant         = grant_r;
    assign busy          = busy_r;
    assign timeout_error = timeout_error_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with TIMEOUT_CYCLES = 8.
module tb_mem_arbiter;
    import requests_pkg::*;

    logic           clock;
    logic           reset;
    cpuMemRequest_t port0_request;
    cpuMemResult_t  port0_result;
    cpuMemRequest_t port1_request;
    cpuMemResult_t  port1_result;
    cpuMemRequest_t mem_request;
    cpuMemResult_t  mem_result;
    logic           grant;
    logic           busy;
    logic           timeout_error;

    int checks   = 0;
    int failures = 0;

    mem_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .port0_request(port0_request),
        .port0_result (port0_result),
        .port1_request(port1_request),
        .port1_result (port1_result),
        .mem_request  (mem_request),
        .mem_result   (mem_result),
        .grant        (grant),
        .busy         (busy),
        .timeout_error(timeout_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic cpuMemRequest_t mk_req(input logic [31:0] a, input logic [31:0] d,
                                              input logic w, input logic p, input logic v);
        cpuMemRequest_t r;
        r.addr = a; r.data = d; r.isWrite = w; r.isPrivaliged = p; r.isValid = v;
        return r;
    endfunction

    function automatic cpuMemResult_t mk_res(input logic [31:0] d, input logic v);
        cpuMemResult_t r;
        r.data = d; r.isValid = v;
        return r;
    endfunction

    cpuMemRequest_t exp_req;
    logic [31:0]    data_v;

    initial begin
        reset         = 1'b1;
        port0_request = '0;
        port1_request = '0;
        mem_result    = '0;
        step();
        step();

        // Reset state
        chk("rst_mem_request", mem_request, 67'h0);
        chk("rst_port0_result", port0_result, 33'h0);
        chk("rst_port1_result", port1_result, 33'h0);
        chk("rst_grant", grant, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_timeout", timeout_error, 1'b0);

        // Single port0 read, memory answers after 3 cycles
        reset = 1'b0;
        port0_request = mk_req(32'h1000, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        chk("p0_req_valid_c1", mem_request.isValid, 1'b1);
        chk("p0_req_addr_c1", mem_request.addr, 32'h1000);
        chk("p0_grant", grant, 1'b0);
        chk("p0_busy", busy, 1'b1);
        step();
        chk("p0_req_stable_c2", mem_request.isValid, 1'b1);
        chk("p0_no_result_c2", port0_result.isValid, 1'b0);
        step();
        mem_result = mk_res(32'hDEAD, 1'b1);
        step();
        chk("p0_result", port0_result, {32'hDEAD, 1'b1});
        chk("p0_p1_invalid", port1_result.isValid, 1'b0);
        chk("p0_req_dropped", mem_request.isValid, 1'b0);
        step();
        port0_request = '0;
        chk("p0_result_one_cycle", port0_result.isValid, 1'b0);
        chk("p0_ignore_respond_res", port1_result.isValid, 1'b0);
        mem_result = '0;
        chk("p0_idle_busy", busy, 1'b0);

        // Contention right after reset: port0 first, then port1
        reset = 1'b1;
        step();
        reset = 1'b0;
        port0_request = mk_req(32'h2000, 32'h0, 1'b0, 1'b0, 1'b1);
        port1_request = mk_req(32'h3000, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        chk("both_first_grant", grant, 1'b0);
        chk("both_first_addr", mem_request.addr, 32'h2000);
        mem_result = mk_res(32'h1111, 1'b1);
        step();
        mem_result = '0;
        chk("both_first_res0", port0_result, {32'h1111, 1'b1});
        chk("both_first_res1", port1_result.isValid, 1'b0);
        step();
        port0_request = '0;
        step();
        chk("both_second_grant", grant, 1'b1);
        chk("both_second_addr", mem_request.addr, 32'h3000);
        mem_result = mk_res(32'h2222, 1'b1);
        step();
        mem_result = '0;
        chk("both_second_res1", port1_result, {32'h2222, 1'b1});
        chk("both_second_res0", port0_result.isValid, 1'b0);
        step();

        // Four rounds of constant contention alternate 0,1,0,1
        port0_request = mk_req(32'hA000, 32'h0, 1'b0, 1'b0, 1'b1);
        port1_request = mk_req(32'hB000, 32'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_grant", grant, (i % 2 == 1) ? 1'b1 : 1'b0);
            chk("rr_addr", mem_request.addr, (i % 2 == 1) ? 32'hB000 : 32'hA000);
            data_v = 32'h100 + 32'(i);
            mem_result = mk_res(data_v, 1'b1);
            step();
            mem_result = '0;
            if (i % 2 == 1) begin
                chk("rr_res1", port1_result, {data_v, 1'b1});
                chk("rr_res0_idle", port0_result.isValid, 1'b0);
            end else begin
                chk("rr_res0", port0_result, {data_v, 1'b1});
                chk("rr_res1_idle", port1_result.isValid, 1'b0);
            end
            step();
        end
        port0_request = '0;
        port1_request = '0;

        // Write request held stable with privilege bit passed through
        exp_req = mk_req(32'h4000, 32'h55, 1'b1, 1'b1, 1'b1);
        port1_request = exp_req;
        step();
        chk("wr_req_c1", mem_request, exp_req);
        step();
        chk("wr_req_c2", mem_request, exp_req);
        step();
        chk("wr_req_c3", mem_request, exp_req);
        mem_result = mk_res(32'h77, 1'b1);
        step();
        mem_result = '0;
        chk("wr_res1", port1_result, {32'h77, 1'b1});
        chk("wr_req_dropped", mem_request.isValid, 1'b0);
        step();
        port1_request = '0;

        // Result arriving on the timeout cycle wins
        port0_request = mk_req(32'h5000, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 7; i++) step();
        chk("race_req_valid_c8", mem_request.isValid, 1'b1);
        mem_result = mk_res(32'hCAFE, 1'b1);
        step();
        mem_result = '0;
        chk("race_res0", port0_result, {32'hCAFE, 1'b1});
        chk("race_no_timeout", timeout_error, 1'b0);
        step();
        port0_request = '0;

        // Memory never answers: abort after 8 busy cycles
        port1_request = mk_req(32'h6000, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        chk("to_grant", grant, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step();
            chk("to_req_held", mem_request.isValid, 1'b1);
            chk("to_no_early_err", timeout_error, 1'b0);
        end
        step();
        chk("to_req_dropped", mem_request.isValid, 1'b0);
        chk("to_error", timeout_error, 1'b1);
        chk("to_res1", port1_result, {32'h0, 1'b1});
        chk("to_res0", port0_result.isValid, 1'b0);
        step();
        port1_request = '0;
        chk("to_error_pulse", timeout_error, 1'b0);
        chk("to_idle", busy, 1'b0);
        chk("to_res_one_cycle", port1_result.isValid, 1'b0);

        // Memory result while idle is ignored
        mem_result = mk_res(32'h9999, 1'b1);
        step();
        mem_result = '0;
        chk("idle_ign_res0", port0_result.isValid, 1'b0);
        chk("idle_ign_res1", port1_result.isValid, 1'b0);
        chk("idle_ign_busy", busy, 1'b0);

        // Reset in the middle of a transaction, then a stale result
        port0_request = mk_req(32'h7000, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        chk("mid_busy", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_async_req", mem_request.isValid, 1'b0);
        chk("mid_async_busy", busy, 1'b0);
        port0_request = '0;
        step();
        reset = 1'b0;
        mem_result = mk_res(32'hBEEF, 1'b1);
        step();
        mem_result = '0;
        chk("stale_res0", port0_result.isValid, 1'b0);
        chk("stale_res1", port1_result.isValid, 1'b0);
        chk("stale_req", mem_request.isValid, 1'b0);
        port0_request = mk_req(32'h8000, 32'h0, 1'b0, 1'b0, 1'b1);
        port1_request = mk_req(32'h9000, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        chk("post_rst_grant", grant, 1'b0);
        chk("post_rst_addr", mem_request.addr, 32'h8000);
        mem_result = mk_res(32'h4242, 1'b1);
        step();
        mem_result = '0;
        chk("post_rst_res0", port0_result, {32'h4242, 1'b1});
        port0_request = '0;
        port1_request = '0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
